// File: rtl/bfly_out_sched.sv
// Radix-2 FFT stage output scheduler: the butterfly sums go straight out,
// the differences are parked and replayed so the output is one continuous NUM-lane stream.
module bfly_out_lane #(
    parameter int W    = 10,
    parameter int HALF = 16,
    parameter int AW   = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          wr_en,
    input  logic [AW-1:0] waddr,
    input  logic [AW-1:0] raddr,
    input  logic          ld_sum,
    input  logic          ld_dif,
    input  logic [W-1:0]  sum_re,
    input  logic [W-1:0]  sum_im,
    input  logic [W-1:0]  dif_re,
    input  logic [W-1:0]  dif_im,
    output logic [W-1:0]  out_re,
    output logic [W-1:0]  out_im
);
    // Difference buffer is never reset; it is always written before it is read.
    logic [2*W-1:0] mem [HALF];

    always_ff @(posedge clk)
        if (wr_en) mem[waddr] <= {dif_re, dif_im};

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            out_re <= '0;
            out_im <= '0;
        end else if (ld_sum) begin
            out_re <= sum_re;
            out_im <= sum_im;
        end else if (ld_dif) begin
            {out_re, out_im} <= mem[raddr];
        end
endmodule

module bfly_out_sched #(
    parameter int W    = 10,
    parameter int NUM  = 16,
    parameter int DATA = 512,
    parameter int HALF = DATA / NUM / 2
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    in_valid,
    input  logic [NUM-1:0][W-1:0]   sum_re,
    input  logic [NUM-1:0][W-1:0]   sum_im,
    input  logic [NUM-1:0][W-1:0]   dif_re,
    input  logic [NUM-1:0][W-1:0]   dif_im,
    output logic                    out_valid,
    output logic [NUM-1:0][W-1:0]   out_re,
    output logic [NUM-1:0][W-1:0]   out_im,
    output logic                    out_sel,
    output logic                    out_last,
    output logic                    err_collision
);
    localparam int AW = (HALF > 1) ? $clog2(HALF) : 1;

    typedef enum logic {FILL, DRAIN} state_t;

    state_t        state, state_nx;
    logic [AW-1:0] wptr, rptr;
    logic          ld_sum, ld_dif, wr_en;
    logic          w_wrap, r_wrap;

    assign w_wrap = (wptr == AW'(HALF - 1));
    assign r_wrap = (rptr == AW'(HALF - 1));

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) state <= FILL;
        else       state <= state_nx;

    // Drain owns the output slot; anything arriving during it is dropped.
    always_comb begin
        state_nx = state;
        ld_sum   = 1'b0;
        ld_dif   = 1'b0;
        wr_en    = 1'b0;
        case (state)
            FILL: if (in_valid) begin
                ld_sum = 1'b1;
                wr_en  = 1'b1;
                if (w_wrap) state_nx = DRAIN;
            end
            DRAIN: begin
                ld_dif = 1'b1;
                if (r_wrap) state_nx = FILL;
            end
            default: state_nx = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            wptr          <= '0;
            rptr          <= '0;
            out_valid     <= 1'b0;
            out_sel       <= 1'b0;
            out_last      <= 1'b0;
            err_collision <= 1'b0;
        end else begin
            out_valid <= ld_sum | ld_dif;
            out_sel   <= ld_dif;
            out_last  <= ld_dif & r_wrap;
            if (state == DRAIN && in_valid) err_collision <= 1'b1;
            if (wr_en) wptr <= w_wrap ? '0 : wptr + AW'(1);
            if (wr_en && w_wrap)      rptr <= '0;
            else if (ld_dif && !r_wrap) rptr <= rptr + AW'(1);
        end

    for (genvar i = 0; i < NUM; i++) begin : g_lane
        bfly_out_lane #(.W(W), .HALF(HALF), .AW(AW)) u_lane (
            .clk    (clk),
            .rstn   (rstn),
            .wr_en  (wr_en),
            .waddr  (wptr),
            .raddr  (rptr),
            .ld_sum (ld_sum),
            .ld_dif (ld_dif),
            .sum_re (sum_re[i]),
            .sum_im (sum_im[i]),
            .dif_re (dif_re[i]),
            .dif_im (dif_im[i]),
            .out_re (out_re[i]),
            .out_im (out_im[i])
        );
    end
endmodule

// File: tb/tb_bfly_out_sched.sv
// Self-checking bench for bfly_out_sched against a queue-based scheduling model.
module tb_bfly_out_sched;
    localparam int W    = 10;
    localparam int NUM  = 16;
    localparam int DATA = 512;
    localparam int HALF = DATA / NUM / 2;
    localparam int BW   = 2 * NUM * W;

    typedef logic [BW-1:0]  beat_t;
    typedef logic [BW+3:0]  vec_t;

    logic                  clk = 1'b0;
    logic                  rstn = 1'b0;
    logic                  in_valid = 1'b0;
    logic [NUM-1:0][W-1:0] sum_re = '0, sum_im = '0, dif_re = '0, dif_im = '0;
    logic                  out_valid, out_sel, out_last, err_collision;
    logic [NUM-1:0][W-1:0] out_re, out_im;

    int errors = 0;
    int checks = 0;

    bfly_out_sched #(.W(W), .NUM(NUM), .DATA(DATA)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid),
        .sum_re(sum_re), .sum_im(sum_im), .dif_re(dif_re), .dif_im(dif_im),
        .out_valid(out_valid), .out_re(out_re), .out_im(out_im),
        .out_sel(out_sel), .out_last(out_last), .err_collision(err_collision)
    );

    always #5 clk = ~clk;

    // Reference: differences collect per frame; a full frame becomes a replay
    // queue that owns the output for HALF beats, during which inputs are lost.
    beat_t pend[$];
    beat_t drq[$];
    logic  m_err;
    vec_t  exp_v;

    task automatic model_reset();
        pend.delete();
        drq.delete();
        m_err = 1'b0;
        exp_v = '0;
    endtask

    task automatic model_edge(input logic v, input beat_t s, input beat_t d);
        logic mv, ms, ml;
        beat_t md;
        mv = 1'b0; ms = 1'b0; ml = 1'b0; md = '0;
        if (drq.size() > 0) begin
            md = drq.pop_front();
            mv = 1'b1; ms = 1'b1;
            ml = (drq.size() == 0);
            if (v) m_err = 1'b1;
        end else if (v) begin
            md = s; mv = 1'b1;
            pend.push_back(d);
            if (pend.size() == HALF) begin
                drq = pend;
                pend.delete();
            end
        end
        exp_v = {mv, ms, ml, m_err, md};
    endtask

    function automatic vec_t obs();
        beat_t d;
        d = out_valid ? beat_t'({out_re, out_im}) : '0;
        return {out_valid, out_valid & out_sel, out_last, err_collision, d};
    endfunction

    function automatic beat_t fill(input int re, input int im);
        logic [NUM-1:0][W-1:0] r, i;
        for (int l = 0; l < NUM; l++) begin
            r[l] = W'(re);
            i[l] = W'(im);
        end
        return {r, i};
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        for (int l = 0; l < BW / 32 + 1; l++) b = {b[BW-33:0], 32'($urandom)};
        return b;
    endfunction

    task automatic step(input logic v, input beat_t s, input beat_t d);
        in_valid = v;
        {sum_re, sum_im} = s;
        {dif_re, dif_im} = d;
        @(posedge clk);
        model_edge(v, s, d);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        model_reset();
        #12;
        checks++;
        if ({out_valid, out_sel, out_last, err_collision, out_re, out_im} !== '0) begin
            errors++;
            $display("FAIL reset_values got=%h exp=0",
                     {out_valid, out_sel, out_last, err_collision, out_re, out_im});
        end
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_frame(input string name);
        int lasts;
        lasts = 0;
        for (int c = 0; c < 2 * HALF + 2; c++) begin
            if (c < HALF) step(1'b1, fill(c, c), fill(-c, -c));
            else          step(1'b0, '0, '0);
            if (out_last) lasts++;
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL %s cyc=%0d got=%h exp=%h", name, c, obs(), exp_v);
            end
        end
        checks++;
        if (lasts != 1) begin
            errors++;
            $display("FAIL %s_last_count got=%0d exp=1", name, lasts);
        end
    endtask

    task automatic test_back_to_back();
        int first, last, nvalid, cyc;
        beat_t s, d;
        first = -1; last = -1; nvalid = 0; cyc = 0;
        for (int f = 0; f < 4; f++)
            for (int c = 0; c < 2 * HALF; c++) begin
                s = (f == 2) ? fill(511, -512) : rand_beat();
                d = (f == 2) ? fill(-512, 511) : rand_beat();
                step(c >= HALF, s, d);
                if (out_valid) begin
                    if (first < 0) first = cyc;
                    last = cyc; nvalid++;
                end
                checks++;
                if (obs() !== exp_v) begin
                    errors++;
                    $display("FAIL b2b f=%0d c=%0d got=%h exp=%h", f, c, obs(), exp_v);
                end
                cyc++;
            end
        for (int c = 0; c < HALF + 2; c++) begin
            step(1'b0, '0, '0);
            if (out_valid) begin last = cyc; nvalid++; end
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL b2b_tail c=%0d got=%h exp=%h", c, obs(), exp_v);
            end
            cyc++;
        end
        checks++;
        if (nvalid != 8 * HALF || last - first + 1 != 8 * HALF) begin
            errors++;
            $display("FAIL b2b_occupancy got=%0d span=%0d exp=%0d", nvalid, last - first + 1, 8 * HALF);
        end
    endtask

    task automatic test_gapped();
        for (int c = 0; c < 2 * HALF + HALF + 2; c++) begin
            if (c < 2 * HALF) step(c % 2 == 0, rand_beat(), rand_beat());
            else              step(1'b0, '0, '0);
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL gapped cyc=%0d got=%h exp=%h", c, obs(), exp_v);
            end
        end
    endtask

    task automatic test_lanes();
        logic [NUM-1:0][W-1:0] sr, si, dr, di;
        for (int l = 0; l < NUM; l++) begin
            sr[l] = W'(l); si[l] = W'(100 + l);
            dr[l] = W'(-(l + 1)); di[l] = W'(-(100 + l));
        end
        for (int c = 0; c < 2 * HALF + 2; c++) begin
            if (c < HALF) step(1'b1, {sr, si}, {dr, di});
            else          step(1'b0, '0, '0);
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL lanes cyc=%0d got=%h exp=%h", c, obs(), exp_v);
            end
        end
    endtask

    task automatic test_collision();
        // Full frame, 12 quiet drain beats, then a burst whose first 4 pairs collide.
        for (int c = 0; c < HALF + 12 + HALF + 4 + HALF + 2; c++) begin
            if (c < HALF || (c >= HALF + 12 && c < 2 * HALF + 16))
                step(1'b1, rand_beat(), rand_beat());
            else
                step(1'b0, '0, '0);
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL collision cyc=%0d got=%h exp=%h", c, obs(), exp_v);
            end
        end
        checks++;
        if (err_collision !== 1'b1) begin
            errors++;
            $display("FAIL collision_sticky got=%b exp=1", err_collision);
        end
    endtask

    task automatic test_reset_mid_drain();
        for (int c = 0; c < HALF + 7; c++) begin
            if (c < HALF) step(1'b1, rand_beat(), rand_beat());
            else          step(1'b0, '0, '0);
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL pre_reset cyc=%0d got=%h exp=%h", c, obs(), exp_v);
            end
        end
        #2 rstn = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({out_valid, out_sel, out_last, err_collision, out_re, out_im} !== '0) begin
            errors++;
            $display("FAIL async_reset got=%h exp=0",
                     {out_valid, out_sel, out_last, err_collision, out_re, out_im});
        end
        #2 rstn = 1'b1;
        test_single_frame("after_reset");
    endtask

    initial begin
        test_reset();
        test_single_frame("single");
        test_back_to_back();
        test_gapped();
        test_lanes();
        test_collision();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
